// File: rtl/key_input_conditioner_if.sv
// key_input_conditioner_if
//   Bundles the button/key signals between the board, the key conditioner
//   and the downstream movement/turn stage.
//   btn_n       : raw active-low buttons {left, right, forward, back}
//   busy        : downstream not ready; holds off new key pulses
//   key_pressed : one-cycle one-hot key event
//   key_held    : debounced active-high button levels
//   master = conditioner side, slave = board/consumer side.
interface key_input_conditioner_if;
    logic [3:0] btn_n;
    logic       busy;
    logic [3:0] key_pressed;
    logic [3:0] key_held;

    modport master (
        input  btn_n,
        input  busy,
        output key_pressed,
        output key_held
    );

    modport slave (
        output btn_n,
        output busy,
        input  key_pressed,
        input  key_held
    );
endinterface

// File: rtl/key_input_conditioner.sv
// key_input_conditioner
//   Turns four raw active-low push-buttons into clean one-hot key pulses for
//   the movement/turn stage: 2-flop synchroniser, per-key debounce, press-edge
//   detection, auto-repeat on selected keys, a pending-event latch and an
//   issue FSM that enforces a lockout after every pulse.
//   clk  : system clock
//   rstn : synchronous active-low reset
//   kif  : master side of key_input_conditioner_if
//          (btn_n, busy in; key_pressed, key_held out)
module key_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [3:0]  REPEAT_MASK     = 4'b0011,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned LOCKOUT_CYCLES  = 1000000
) (
    input logic                      clk,
    input logic                      rstn,
    key_input_conditioner_if.master  kif
);

    localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RpW    = (RepMax > 1) ? $clog2(RepMax) : 1;
    localparam int unsigned LkW    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [DbW-1:0] DbLast     = DbW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic [RpW-1:0] DelayLast  = RpW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RpW-1:0] PeriodLast = RpW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
    localparam logic [LkW-1:0] LockLast   = LkW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {StIdle, StFire, StLock} state_e;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [3:0] sync1_q, sync2_q, sync;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= kif.btn_n;
            sync2_q <= sync1_q;
        end
    end

    assign sync = ~sync2_q;

    // ------------------------------------------------------------------
    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
    // differing samples; any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    logic [3:0][DbW-1:0] db_cnt_q, db_cnt_d;
    logic [3:0]          stable_q, stable_d, stable_prev_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            stable_d[i] = stable_q[i];
            if (sync[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat: first event REPEAT_DELAY cycles after the stable press,
    // then every REPEAT_PERIOD cycles. The counter reloads at each event so
    // it never wraps.
    // ------------------------------------------------------------------
    logic [3:0][RpW-1:0] rep_cnt_q, rep_cnt_d;
    logic [3:0]          rep_first_q, rep_first_d, rep_evt;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rep_evt[i]     = 1'b0;
            rep_cnt_d[i]   = '0;
            rep_first_d[i] = 1'b1;
            if (REPEAT_MASK[i] && stable_q[i]) begin
                rep_first_d[i] = rep_first_q[i];
                if (rep_cnt_q[i] == (rep_first_q[i] ? DelayLast : PeriodLast)) begin
                    rep_evt[i]     = 1'b1;
                    rep_first_d[i] = 1'b0;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending latch and issue FSM
    // ------------------------------------------------------------------
    logic [3:0]     press_evt, pending_q, pending_d, clr;
    state_e         state_q, state_d;
    logic [1:0]     winner_q, winner_d;
    logic [LkW-1:0] lock_cnt_q, lock_cnt_d;
    logic [3:0]     key_pressed_q, key_pressed_d;

    assign press_evt = stable_q & ~stable_prev_q;

    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        lock_cnt_d    = lock_cnt_q;
        clr           = 4'b0000;
        key_pressed_d = 4'b0000;

        unique case (state_q)
            StIdle: begin
                if ((pending_q != 4'b0000) && !kif.busy) begin
                    if (pending_q[3])      winner_d = 2'd3;
                    else if (pending_q[2]) winner_d = 2'd2;
                    else if (pending_q[1]) winner_d = 2'd1;
                    else                   winner_d = 2'd0;
                    state_d       = StFire;
                    // Registered output: high exactly during the FIRE cycle.
                    key_pressed_d = 4'b0001 << winner_d;
                end
            end
            StFire: begin
                clr        = 4'b0001 << winner_q;
                lock_cnt_d = '0;
                state_d    = (LOCKOUT_CYCLES > 0) ? StLock : StIdle;
            end
            StLock: begin
                if (lock_cnt_q == LockLast) begin
                    lock_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new event in the clearing cycle survives (set wins).
        pending_d = (pending_q & ~clr) | press_evt | rep_evt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            db_cnt_q      <= '0;
            stable_q      <= 4'b0000;
            stable_prev_q <= 4'b0000;
            rep_cnt_q     <= '0;
            rep_first_q   <= 4'b1111;
            pending_q     <= 4'b0000;
            state_q       <= StIdle;
            winner_q      <= 2'd0;
            lock_cnt_q    <= '0;
            key_pressed_q <= 4'b0000;
        end else begin
            db_cnt_q      <= db_cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            rep_cnt_q     <= rep_cnt_d;
            rep_first_q   <= rep_first_d;
            pending_q     <= pending_d;
            state_q       <= state_d;
            winner_q      <= winner_d;
            lock_cnt_q    <= lock_cnt_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    assign kif.key_pressed = key_pressed_q;
    assign kif.key_held    = stable_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// tb_key_input_conditioner
//   Directed bench for key_input_conditioner with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=20, REPEAT_PERIOD=8, LOCKOUT_CYCLES=3.
//   Each scenario is a list of input segments; outputs are logged per edge
//   (edge 0 = first edge that samples the scenario's first inputs) and
//   compared against hand-computed checkpoints and pulse counts.
//   Edge timeline for a clean press sampled at edge 0:
//     sync valid e1, debounce counts e2..e4, key_held rises e5,
//     pending e6, FIRE (key_pressed) e7, LOCK e8..e10, IDLE e11.
module tb_key_input_conditioner;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    key_input_conditioner_if kif();

    key_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_MASK     (4'b0011),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .LOCKOUT_CYCLES  (3)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .kif  (kif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         scen;
        int         n;
        logic [3:0] btn_n;
        logic       busy;
        logic       rstn;
    } seg_t;

    typedef struct {
        int         scen;
        int         edge_i;
        logic [3:0] kp;
        logic [3:0] kh;
    } chk_t;

    seg_t segs[$];
    chk_t chks[$];

    string sname [6] = '{"hold_fwd", "bounce_left", "left_and_back",
                         "busy_right", "reset_in_lock", "hold_right"};
    int    exp_pulses [6] = '{4, 0, 2, 1, 1, 1};

    logic [3:0] kp_log [0:127];
    logic [3:0] kh_log [0:127];

    int n_vec = 0;
    int n_bad = 0;

    task automatic step(input logic [3:0] b, input logic bz, input logic r, input int idx);
        kif.btn_n = b;
        kif.busy  = bz;
        rstn      = r;
        @(posedge clk);
        #1;
        if (idx >= 0 && idx < 128) begin
            kp_log[idx] = kif.key_pressed;
            kh_log[idx] = kif.key_held;
        end
    endtask

    task automatic run_scen(input int s);
        int idx;
        int pulses;
        int multi;
        // Clean start for every scenario.
        step(4'b1111, 1'b0, 1'b0, -1);
        step(4'b1111, 1'b0, 1'b0, -1);
        step(4'b1111, 1'b0, 1'b1, -1);
        idx = 0;
        for (int k = 0; k < segs.size(); k++) begin
            if (segs[k].scen == s) begin
                for (int j = 0; j < segs[k].n; j++) begin
                    step(segs[k].btn_n, segs[k].busy, segs[k].rstn, idx);
                    idx++;
                end
            end
        end
        for (int k = 0; k < chks.size(); k++) begin
            if (chks[k].scen == s) begin
                n_vec++;
                if (kp_log[chks[k].edge_i] !== chks[k].kp ||
                    kh_log[chks[k].edge_i] !== chks[k].kh) begin
                    n_bad++;
                    $display("FAIL %s edge %0d: key_pressed=%b key_held=%b, required %b %b",
                             sname[s], chks[k].edge_i, kp_log[chks[k].edge_i],
                             kh_log[chks[k].edge_i], chks[k].kp, chks[k].kh);
                end
            end
        end
        pulses = 0;
        multi  = 0;
        for (int e = 0; e < idx; e++) begin
            if (kp_log[e] !== 4'b0000) pulses++;
            if ($countones(kp_log[e]) > 1) multi++;
        end
        n_vec++;
        if (pulses != exp_pulses[s]) begin
            n_bad++;
            $display("FAIL %s pulse_count: got %0d, required %0d", sname[s], pulses,
                     exp_pulses[s]);
        end
        n_vec++;
        if (multi != 0) begin
            n_bad++;
            $display("FAIL %s onehot: %0d multi-bit cycles, required 0", sname[s], multi);
        end
    endtask

    initial begin
        // 0: forward held 40 edges; press pulse e7, repeat events at
        //    key_held+20 (e25) and +28 (e33), one more at e41 before the
        //    release debounces (e45); each pulse one edge after its event.
        segs.push_back('{0, 40, 4'b1101, 1'b0, 1'b1});
        segs.push_back('{0, 20, 4'b1111, 1'b0, 1'b1});
        chks.push_back('{0,  4, 4'b0000, 4'b0000});
        chks.push_back('{0,  5, 4'b0000, 4'b0010});
        chks.push_back('{0,  6, 4'b0000, 4'b0010});
        chks.push_back('{0,  7, 4'b0010, 4'b0010});
        chks.push_back('{0,  8, 4'b0000, 4'b0010});
        chks.push_back('{0, 25, 4'b0000, 4'b0010});
        chks.push_back('{0, 26, 4'b0010, 4'b0010});
        chks.push_back('{0, 27, 4'b0000, 4'b0010});
        chks.push_back('{0, 34, 4'b0010, 4'b0010});
        chks.push_back('{0, 42, 4'b0010, 4'b0010});
        chks.push_back('{0, 44, 4'b0000, 4'b0010});
        chks.push_back('{0, 45, 4'b0000, 4'b0000});
        // 1: bounce on left: low 2, high 1, low 2 -> never 4 in a row.
        segs.push_back('{1,  2, 4'b0111, 1'b0, 1'b1});
        segs.push_back('{1,  1, 4'b1111, 1'b0, 1'b1});
        segs.push_back('{1,  2, 4'b0111, 1'b0, 1'b1});
        segs.push_back('{1, 15, 4'b1111, 1'b0, 1'b1});
        chks.push_back('{1,  4, 4'b0000, 4'b0000});
        chks.push_back('{1,  6, 4'b0000, 4'b0000});
        chks.push_back('{1,  8, 4'b0000, 4'b0000});
        // 2: left + back together: left at e7, back after FIRE, 3x LOCK, IDLE -> e12.
        segs.push_back('{2, 10, 4'b0110, 1'b0, 1'b1});
        segs.push_back('{2, 20, 4'b1111, 1'b0, 1'b1});
        chks.push_back('{2,  5, 4'b0000, 4'b1001});
        chks.push_back('{2,  7, 4'b1000, 4'b1001});
        chks.push_back('{2,  8, 4'b0000, 4'b1001});
        chks.push_back('{2, 11, 4'b0000, 4'b1001});
        chks.push_back('{2, 12, 4'b0001, 4'b1001});
        chks.push_back('{2, 13, 4'b0000, 4'b1001});
        // 3: right pressed/released under busy; busy drops before e30.
        segs.push_back('{3, 10, 4'b1011, 1'b1, 1'b1});
        segs.push_back('{3, 20, 4'b1111, 1'b1, 1'b1});
        segs.push_back('{3, 15, 4'b1111, 1'b0, 1'b1});
        chks.push_back('{3,  5, 4'b0000, 4'b0100});
        chks.push_back('{3, 15, 4'b0000, 4'b0000});
        chks.push_back('{3, 29, 4'b0000, 4'b0000});
        chks.push_back('{3, 30, 4'b0100, 4'b0000});
        chks.push_back('{3, 31, 4'b0000, 4'b0000});
        // 4: forward + back; forward fires e7, back pending; reset at e9 (LOCK).
        segs.push_back('{4,  9, 4'b1100, 1'b0, 1'b1});
        segs.push_back('{4,  1, 4'b1111, 1'b0, 1'b0});
        segs.push_back('{4, 30, 4'b1111, 1'b0, 1'b1});
        chks.push_back('{4,  7, 4'b0010, 4'b0011});
        chks.push_back('{4,  8, 4'b0000, 4'b0011});
        chks.push_back('{4,  9, 4'b0000, 4'b0000});
        chks.push_back('{4, 10, 4'b0000, 4'b0000});
        // 5: turn key held 50 edges: single pulse, no repeat.
        segs.push_back('{5, 50, 4'b1011, 1'b0, 1'b1});
        segs.push_back('{5, 20, 4'b1111, 1'b0, 1'b1});
        chks.push_back('{5,  7, 4'b0100, 4'b0100});
        chks.push_back('{5, 30, 4'b0000, 4'b0100});
        chks.push_back('{5, 54, 4'b0000, 4'b0100});
        chks.push_back('{5, 55, 4'b0000, 4'b0000});

        // Reset state.
        step(4'b1111, 1'b0, 1'b0, -1);
        step(4'b1111, 1'b0, 1'b0, -1);
        n_vec++;
        if (kif.key_pressed !== 4'b0000 || kif.key_held !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_state: key_pressed=%b key_held=%b, required 0000 0000",
                     kif.key_pressed, kif.key_held);
        end

        for (int s = 0; s < 6; s++) begin
            run_scen(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
